// File: rtl/ltc2333_pkg.sv
// Shared types and default timing for the LTC2333 conversion controller.
// Timing constants are in clk cycles.
package ltc2333_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CNV_HI,
        CONV_WAIT,
        SHIFT
    } state_t;

    localparam int CFG_W     = 8;
    localparam int CFG_DEPTH = 16;

    typedef logic [CFG_W-1:0] cfg_word_t;

    localparam int DEF_CLK_DIV     = 2;
    localparam int DEF_CNV_HIGH    = 8;
    localparam int DEF_CONV_CYCLES = 96;
    localparam int DEF_N_SCK       = 12;

    // A zero period would never fire, so it behaves as a trigger every cycle.
    function automatic logic [15:0] eff_period(input logic [15:0] p);
        return (p == 16'd0) ? 16'd1 : p;
    endfunction

endpackage

// File: rtl/ltc2333_sck_gen.sv
// SCKI burst generator: after a start pulse, emits N_SCK periods of
// CLK_DIV low / CLK_DIV high, with edge strobes and a completion flag.
module ltc2333_sck_gen
    import ltc2333_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int N_SCK   = DEF_N_SCK
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic scki,
    output logic rise,
    output logic fall,
    output logic done
);

    localparam int NW = $clog2(N_SCK + 1);

    logic          active;
    logic [7:0]    ph_cnt;
    logic [NW-1:0] per_cnt;
    logic          ph_end;

    // Strobes are asserted in the cycle before scki toggles, so logic that
    // reacts to them updates on the same edge as scki.
    assign ph_end = active && (ph_cnt == 8'(CLK_DIV - 1));
    assign rise   = ph_end && !scki;
    assign fall   = ph_end && scki;
    assign done   = fall && (per_cnt == NW'(N_SCK - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            scki    <= 1'b0;
            ph_cnt  <= '0;
            per_cnt <= '0;
        end else if (start) begin
            active  <= 1'b1;
            scki    <= 1'b0;
            ph_cnt  <= '0;
            per_cnt <= '0;
        end else if (active) begin
            if (ph_end) begin
                ph_cnt <= '0;
                scki   <= !scki;
                if (fall) begin
                    if (done) active <= 1'b0;
                    else      per_cnt <= per_cnt + 1'b1;
                end
            end else begin
                ph_cnt <= ph_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ltc2333_ctrl.sv
// LTC2333 frame controller: trigger select, CNV pulse, conversion wait and
// SoftSpan word shift-out with a sequenced 16-entry config table.
module ltc2333_ctrl
    import ltc2333_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int CNV_HIGH    = DEF_CNV_HIGH,
    parameter int CONV_CYCLES = DEF_CONV_CYCLES,
    parameter int N_SCK       = DEF_N_SCK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        free_run,
    input  logic [15:0] period,
    input  logic        trig,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    input  logic [3:0]  seq_len,
    output logic        cnv,
    output logic        scki,
    output logic        sdi,
    output logic        busy,
    output logic [3:0]  step,
    output logic        overrun
);

    state_t    state;
    cfg_word_t cfg [CFG_DEPTH];
    cfg_word_t sh;
    logic [3:0]  bit_cnt;
    logic [9:0]  cnt;
    logic [15:0] pcnt;
    logic [15:0] per_last;
    logic        trig_q;
    logic        hit;
    logic        trigger;
    logic        sck_start;
    logic        sck_rise;
    logic        sck_fall;
    logic        sck_done;

    assign per_last  = eff_period(period) - 16'd1;
    assign hit       = (pcnt == per_last);
    assign trigger   = free_run ? hit : (trig && !trig_q);
    assign sck_start = (state == CONV_WAIT) && (cnt == 10'(CONV_CYCLES - 1));

    ltc2333_sck_gen #(
        .CLK_DIV (CLK_DIV),
        .N_SCK   (N_SCK)
    ) u_sck (
        .clk   (clk),
        .reset (reset),
        .start (sck_start),
        .scki  (scki),
        .rise  (sck_rise),
        .fall  (sck_fall),
        .done  (sck_done)
    );

    // Free-running period counter; the >= also recovers when period shrinks.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt   <= '0;
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig;
            if (pcnt >= per_last) pcnt <= '0;
            else                  pcnt <= pcnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CFG_DEPTH; i++) cfg[i] <= '0;
        end else if (cfg_we) begin
            cfg[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnv     <= 1'b0;
            busy    <= 1'b0;
            sdi     <= 1'b0;
            step    <= '0;
            overrun <= 1'b0;
            cnt     <= '0;
            sh      <= '0;
            bit_cnt <= '0;
        end else begin
            if (!enable)                         overrun <= 1'b0;
            else if (trigger && state != IDLE)   overrun <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (trigger && enable) begin
                        state <= CNV_HI;
                        cnv   <= 1'b1;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CNV_HI: begin
                    if (cnt == 10'(CNV_HIGH - 1)) begin
                        state <= CONV_WAIT;
                        cnv   <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                CONV_WAIT: begin
                    if (sck_start) begin
                        // Private copy so table writes cannot disturb this frame.
                        state   <= SHIFT;
                        sh      <= cfg[step];
                        sdi     <= cfg[step][CFG_W-1];
                        bit_cnt <= '0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                SHIFT: begin
                    if (sck_rise) bit_cnt <= bit_cnt + 4'd1;
                    if (sck_fall) begin
                        sh  <= {sh[CFG_W-2:0], 1'b0};
                        sdi <= (bit_cnt < 4'(CFG_W)) ? sh[CFG_W-2] : 1'b0;
                    end
                    if (sck_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        sdi   <= 1'b0;
                        step  <= (step >= seq_len) ? 4'd0 : step + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
